neuron_sequencer: RTL and testbench

//  Drives one neuron datapath (sign-magnitude 8b MAC + activation) from an upstream valid/ready stream of (input, weight) pairs.

---
 rtl/neuron_pkg.sv | 25 ++
 rtl/lat_pipe.sv | 22 ++
 rtl/neuron_sequencer.sv | 129 ++++++++++++
 tb/tb_neuron_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron sequencer: width helpers and the FSM state encoding.
package neuron_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Datapath accumulator grows by one bit per doubling of the product count.
  function automatic int acc_width(input int n);
    return 16 + clog2(n);
  endfunction

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED  = 3'd1,
    DRAIN = 3'd2,
    FIRE  = 3'd3,
    HOLD  = 3'd4,
    CLEAR = 3'd5
  } state_t;

endpackage

// File: rtl/lat_pipe.sv
// Valid-bit shift register that tracks products in flight through the multiplier.
module lat_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic out_valid,
  output logic empty
);

  logic [DEPTH-1:0] pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pipe <= '0;
    else      pipe <= (pipe << 1) | DEPTH'(in_valid);
  end

  assign out_valid = pipe[DEPTH-1];
  assign empty     = ~|pipe;

endmodule

// File: rtl/neuron_sequencer.sv
// Sequences one neuron: streams N (input, weight) pairs into the MAC datapath,
// fires the activation once all products are accumulated and hands back the result.
module neuron_sequencer
  import neuron_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MULT_LAT = 1,
  localparam int ACC_W    = acc_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_in,
  input  logic [7:0]       s_weight,
  output logic             dp_ldIn,
  output logic             dp_ldWeight,
  output logic [7:0]       dp_in,
  output logic [7:0]       dp_inWeight,
  output logic             dp_ldNReg,
  output logic             dp_count_up,
  output logic             dp_clr,
  output logic             dp_ready,
  input  logic             dp_count_cout,
  input  logic [ACC_W-1:0] dp_outActive,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             err
);

  localparam int CW = clog2(N + 1);
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);

  state_t state, state_next;
  logic [CW-1:0] acc_cnt, prod_cnt;
  logic accept, ld_nreg, pipe_empty;

  assign s_ready = (state == FEED) && (acc_cnt != N_C);
  assign accept  = s_valid && s_ready;

  lat_pipe #(.DEPTH(MULT_LAT + 1)) u_lat_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .out_valid(ld_nreg),
    .empty    (pipe_empty)
  );

  assign dp_ldNReg   = ld_nreg;
  assign dp_count_up = ld_nreg;
  assign dp_ready    = (state == FIRE);
  assign dp_clr      = (state == CLEAR);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FEED;
      FEED:    if (accept && acc_cnt == LAST_C) state_next = DRAIN;
      DRAIN:   if (pipe_empty && prod_cnt == N_C) state_next = FIRE;
      FIRE:    state_next = HOLD;
      HOLD:    if (res_valid && res_ready) state_next = CLEAR;
      CLEAR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_in       <= '0;
      dp_inWeight <= '0;
      dp_ldIn     <= 1'b0;
      dp_ldWeight <= 1'b0;
    end else begin
      dp_ldIn     <= accept;
      dp_ldWeight <= accept;
      if (accept) begin
        dp_in       <= s_in;
        dp_inWeight <= s_weight;
      end
    end
  end

  // Both counts saturate at N; CLEAR rearms them for the next neuron.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt  <= '0;
      prod_cnt <= '0;
    end else if (state == CLEAR) begin
      acc_cnt  <= '0;
      prod_cnt <= '0;
    end else begin
      if (accept && acc_cnt != N_C)   acc_cnt  <= acc_cnt + CW'(1);
      if (ld_nreg && prod_cnt != N_C) prod_cnt <= prod_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (state == FIRE) begin
      res_valid <= 1'b1;
      res_data  <= dp_outActive;
    end else if (state == HOLD && res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Terminal count must appear exactly when our own product count reaches N.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else begin
      if ((state == FEED || state == DRAIN) && dp_count_cout && prod_cnt != N_C) err <= 1'b1;
      if (state == FIRE && !dp_count_cout) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Bench for neuron_sequencer with a behavioural sign-magnitude MAC datapath beside each instance.
module tb_neuron_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int checks = 0;
  int errors = 0;

  logic        start, s_valid, s_ready, res_ready, res_valid, busy, err;
  logic [7:0]  s_in, s_weight, dp_in, dp_inWeight;
  logic        dp_ldIn, dp_ldWeight, dp_ldNReg, dp_count_up, dp_clr, dp_ready, dp_count_cout;
  logic [17:0] dp_outActive, res_data;
  logic        force_cout;

  logic        start_b, s_valid_b, s_ready_b, res_ready_b, res_valid_b, busy_b, err_b;
  logic [7:0]  s_in_b, s_weight_b, dp_in_b, dp_inWeight_b;
  logic        dp_ldIn_b, dp_ldWeight_b, dp_ldNReg_b, dp_count_up_b, dp_clr_b, dp_ready_b, dp_count_cout_b;
  logic [15:0] dp_outActive_b, res_data_b;

  function automatic logic signed [15:0] sm_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] mag;
    mag = 16'(a[6:0]) * 16'(b[6:0]);
    return (a[7] ^ b[7]) ? -signed'(mag) : signed'(mag);
  endfunction

  neuron_sequencer #(.N(4), .MULT_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_in(s_in), .s_weight(s_weight), .dp_ldIn(dp_ldIn), .dp_ldWeight(dp_ldWeight),
    .dp_in(dp_in), .dp_inWeight(dp_inWeight), .dp_ldNReg(dp_ldNReg), .dp_count_up(dp_count_up),
    .dp_clr(dp_clr), .dp_ready(dp_ready), .dp_count_cout(dp_count_cout), .dp_outActive(dp_outActive),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .err(err)
  );

  neuron_sequencer #(.N(1), .MULT_LAT(0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
    .s_in(s_in_b), .s_weight(s_weight_b), .dp_ldIn(dp_ldIn_b), .dp_ldWeight(dp_ldWeight_b),
    .dp_in(dp_in_b), .dp_inWeight(dp_inWeight_b), .dp_ldNReg(dp_ldNReg_b), .dp_count_up(dp_count_up_b),
    .dp_clr(dp_clr_b), .dp_ready(dp_ready_b), .dp_count_cout(dp_count_cout_b), .dp_outActive(dp_outActive_b),
    .busy(busy_b), .res_valid(res_valid_b), .res_ready(res_ready_b), .res_data(res_data_b), .err(err_b)
  );

  // Datapath A: one multiplier register stage, 18b accumulator, product counter, ReLU.
  logic signed [15:0] prod_pipe_a;
  logic signed [17:0] acc_a;
  logic [2:0]         cnt_a;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_pipe_a <= '0;
      acc_a       <= '0;
      cnt_a       <= '0;
    end else begin
      prod_pipe_a <= sm_mul(dp_in, dp_inWeight);
      if (dp_clr) begin
        acc_a <= '0;
        cnt_a <= '0;
      end else begin
        if (dp_ldNReg)   acc_a <= acc_a + 18'(prod_pipe_a);
        if (dp_count_up) cnt_a <= cnt_a + 3'd1;
      end
    end
  end

  assign dp_count_cout = (cnt_a == 3'd4) | force_cout;
  assign dp_outActive  = (dp_ready && !acc_a[17]) ? acc_a : '0;

  // Datapath B: combinational multiplier, single product.
  logic signed [15:0] acc_b;
  logic               cnt_b;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_b <= '0;
      cnt_b <= 1'b0;
    end else if (dp_clr_b) begin
      acc_b <= '0;
      cnt_b <= 1'b0;
    end else begin
      if (dp_ldNReg_b)   acc_b <= acc_b + sm_mul(dp_in_b, dp_inWeight_b);
      if (dp_count_up_b) cnt_b <= 1'b1;
    end
  end

  assign dp_count_cout_b = cnt_b;
  assign dp_outActive_b  = (dp_ready_b && !acc_b[15]) ? acc_b : '0;

  // Byte i of each word is pair i.  Products 6, 5, -4, 4 sum to 11.
  localparam logic [31:0] MIX_IN = {8'h02, 8'h81, 8'h05, 8'h03};
  localparam logic [31:0] MIX_W  = {8'h02, 8'h04, 8'h01, 8'h02};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_pairs(input logic [31:0] ins, input logic [31:0] ws, input int gap,
                            input int force_at, output logic [31:0] ld_hist, output logic [31:0] acc_hist);
    int   idx;
    int   gap_cnt;
    logic acc_now;
    idx = 0;
    gap_cnt = 0;
    ld_hist = '0;
    acc_hist = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      force_cout  = (k == force_at);
      s_valid     = (idx < 4) && (gap_cnt == 0);
      s_in        = ins[8*(idx%4) +: 8];
      s_weight    = ws[8*(idx%4) +: 8];
      acc_now     = s_valid & s_ready;
      acc_hist[k] = acc_now;
      ld_hist[k]  = dp_ldNReg;
      step();
      if (acc_now) begin
        idx++;
        gap_cnt = gap;
      end else if (gap_cnt > 0) begin
        gap_cnt--;
      end
    end
    s_valid = 1'b0;
    force_cout = 1'b0;
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    step();
    checks++;
    if ({busy, s_ready, res_valid, err, dp_ldIn, dp_ldWeight, dp_ldNReg, dp_count_up, dp_clr, dp_ready} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0", {busy, s_ready, res_valid, err, dp_ldIn, dp_ldWeight, dp_ldNReg, dp_count_up, dp_clr, dp_ready});
    end
    checks++;
    if ({res_data, dp_in, dp_inWeight} !== 34'b0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected 0", {res_data, dp_in, dp_inWeight});
    end
    rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got busy=%b s_ready=%b expected 0 0", busy, s_ready);
    end
  endtask

  task automatic test_stream();
    logic [31:0] ld, acc;
    feed_pairs(MIX_IN, MIX_W, 0, -1, ld, acc);
    checks++;
    if (acc !== 32'h0000_000F) begin errors++; $display("[TB] FAIL stream_accepts: got %h expected 0000000f", acc); end
    checks++;
    if (ld !== 32'h0000_003C) begin errors++; $display("[TB] FAIL stream_ldnreg: got %h expected 0000003c", ld); end
    checks++;
    if (res_valid !== 1'b1 || res_data !== 18'd11) begin
      errors++;
      $display("[TB] FAIL stream_result: got valid=%b data=%0d expected 1 11", res_valid, res_data);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL stream_err: got %b expected 0", err); end
    take_result();
    checks++;
    if (dp_clr !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_clear: got clr=%b valid=%b expected 1 0", dp_clr, res_valid);
    end
    step();
    checks++;
    if (busy !== 1'b0 || dp_clr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_idle: got busy=%b clr=%b expected 0 0", busy, dp_clr);
    end
  endtask

  task automatic test_gaps();
    logic [31:0] ld, acc;
    feed_pairs(MIX_IN, MIX_W, 2, -1, ld, acc);
    checks++;
    if (acc !== 32'h0000_0249) begin errors++; $display("[TB] FAIL gap_accepts: got %h expected 00000249", acc); end
    checks++;
    if (ld !== 32'h0000_0924) begin errors++; $display("[TB] FAIL gap_ldnreg: got %h expected 00000924", ld); end
    checks++;
    if (res_data !== 18'd11) begin errors++; $display("[TB] FAIL gap_result: got %0d expected 11", res_data); end
    take_result();
    step();
  endtask

  task automatic test_hold_stall();
    logic [31:0] ld, acc;
    feed_pairs(MIX_IN, MIX_W, 0, -1, ld, acc);
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({res_valid, dp_clr, res_data} !== {1'b1, 1'b0, 18'd11}) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: got valid=%b clr=%b data=%0d expected 1 0 11", i, res_valid, dp_clr, res_data);
      end
    end
    take_result();
    checks++;
    if (dp_clr !== 1'b1) begin errors++; $display("[TB] FAIL stall_clear: got %b expected 1", dp_clr); end
    step();
    feed_pairs(32'h0101_0101, 32'h0101_0101, 0, -1, ld, acc);
    checks++;
    if (res_data !== 18'd4) begin errors++; $display("[TB] FAIL second_neuron: got %0d expected 4", res_data); end
    take_result();
    step();
  endtask

  task automatic test_negative();
    logic [31:0] ld, acc;
    feed_pairs(32'h8585_8585, 32'h0303_0303, 0, -1, ld, acc);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 18'd0) begin
      errors++;
      $display("[TB] FAIL negative_relu: got valid=%b data=%0d expected 1 0", res_valid, res_data);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({busy, res_valid, s_ready} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL start_in_hold: got %b expected 110", {busy, res_valid, s_ready});
    end
    take_result();
    step();
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL start_ignored: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ld, acc;
    start = 1'b1;
    step();
    start = 1'b0;
    s_valid = 1'b1; s_in = 8'h03; s_weight = 8'h02;
    step();
    s_in = 8'h05; s_weight = 8'h01;
    step();
    s_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, s_ready, res_valid, err, dp_ldNReg, dp_ldIn, dp_clr, dp_ready} !== 8'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got %b expected 0", {busy, s_ready, res_valid, err, dp_ldNReg, dp_ldIn, dp_clr, dp_ready});
    end
    step();
    rst = 1'b1;
    step();
    feed_pairs(MIX_IN, MIX_W, 0, -1, ld, acc);
    checks++;
    if (res_data !== 18'd11 || err !== 1'b0 || ld !== 32'h0000_003C) begin
      errors++;
      $display("[TB] FAIL after_reset: got data=%0d err=%b ld=%h expected 11 0 0000003c", res_data, err, ld);
    end
    take_result();
    step();
  endtask

  task automatic test_err();
    logic [31:0] ld, acc;
    feed_pairs(MIX_IN, MIX_W, 0, 1, ld, acc);
    checks++;
    if (err !== 1'b1 || res_data !== 18'd11) begin
      errors++;
      $display("[TB] FAIL err_set: got err=%b data=%0d expected 1 11", err, res_data);
    end
    take_result();
    step();
    checks++;
    if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b expected 1", err); end
    rst = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_clear: got %b expected 0", err); end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_n1();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    s_valid_b = 1'b1; s_in_b = 8'h07; s_weight_b = 8'h07;
    checks++;
    if (s_ready_b !== 1'b1) begin errors++; $display("[TB] FAIL n1_ready: got %b expected 1", s_ready_b); end
    step();
    s_valid_b = 1'b0;
    checks++;
    if ({dp_ldNReg_b, dp_ldIn_b, s_ready_b} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL n1_ldnreg: got %b expected 110", {dp_ldNReg_b, dp_ldIn_b, s_ready_b});
    end
    for (int i = 0; i < 10 && !res_valid_b; i++) step();
    checks++;
    if (res_valid_b !== 1'b1 || res_data_b !== 16'd49 || err_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL n1_result: got valid=%b data=%0d err=%b expected 1 49 0", res_valid_b, res_data_b, err_b);
    end
    res_ready_b = 1'b1;
    step();
    res_ready_b = 1'b0;
    checks++;
    if (dp_clr_b !== 1'b1) begin errors++; $display("[TB] FAIL n1_clear: got %b expected 1", dp_clr_b); end
    step();
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0; s_valid = 1'b0; s_in = '0; s_weight = '0; res_ready = 1'b0; force_cout = 1'b0;
    start_b = 1'b0; s_valid_b = 1'b0; s_in_b = '0; s_weight_b = '0; res_ready_b = 1'b0;
    test_reset();
    test_stream();
    test_gaps();
    test_hold_stall();
    test_negative();
    test_reset_mid();
    test_err();
    test_n1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
